// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with a down-counting timer source.
// Latches source edges into sticky pending bits and routes them to irq or firq.
module irq_ctrl #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [31:0]     write_data,
  output logic [31:0]     read_data,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  output logic            firq
);

  localparam int P = NSRC + 1;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_ENABLE  = 3'd1;
  localparam logic [2:0] REG_FIQSEL  = 3'd2;
  localparam logic [2:0] REG_CLEAR   = 3'd3;
  localparam logic [2:0] REG_LOAD    = 3'd4;
  localparam logic [2:0] REG_VALUE   = 3'd5;
  localparam logic [2:0] REG_TCTRL   = 3'd6;
  localparam logic [2:0] REG_ID      = 3'd7;

  logic [NSRC-1:0] src_q;
  logic [P-1:0]    pending;
  logic [P-1:0]    enable;
  logic [P-1:0]    fiqsel;
  logic [31:0]     load_val;
  logic [31:0]     value;
  logic            tmr_en;
  logic            tmr_periodic;

  logic [2:0]      reg_idx;
  logic            wr;
  logic            wr_enable;
  logic            wr_fiqsel;
  logic            wr_clear;
  logic            wr_load;
  logic            wr_tctrl;
  logic            tmr_fire;
  logic [P-1:0]    set_mask;
  logic [P-1:0]    clr_mask;
  logic [P-1:0]    irq_mask;
  logic [P-1:0]    firq_mask;
  logic [5:0]      irq_id;
  logic            unused_addr;

  assign unused_addr = ^{addr[31:5], addr[1:0]};

  assign reg_idx   = addr[4:2];
  assign wr        = sel & we;
  assign wr_enable = wr && (reg_idx == REG_ENABLE);
  assign wr_fiqsel = wr && (reg_idx == REG_FIQSEL);
  assign wr_clear  = wr && (reg_idx == REG_CLEAR);
  assign wr_load   = wr && (reg_idx == REG_LOAD);
  assign wr_tctrl  = wr && (reg_idx == REG_TCTRL);

  assign tmr_fire  = tmr_en && (value == 32'd0);
  assign set_mask  = {tmr_fire, src & ~src_q};
  assign clr_mask  = wr_clear ? write_data[P-1:0] : '0;
  assign irq_mask  = pending & enable & ~fiqsel;
  assign firq_mask = pending & enable & fiqsel;

  // Set is applied after clear so a same-cycle set event wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      pending <= '0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable <= '0;
      fiqsel <= '0;
    end else begin
      if (wr_enable) enable <= write_data[P-1:0];
      if (wr_fiqsel) fiqsel <= write_data[P-1:0];
    end
  end

  // A LOAD write preloads the count and overrides this cycle's countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_val     <= '0;
      value        <= '0;
      tmr_en       <= 1'b0;
      tmr_periodic <= 1'b0;
    end else begin
      if (wr_load) load_val <= write_data;

      if (wr_tctrl) begin
        tmr_en       <= write_data[0];
        tmr_periodic <= write_data[1];
      end else if (tmr_fire && !tmr_periodic) begin
        tmr_en <= 1'b0;
      end

      if (wr_load) begin
        value <= write_data;
      end else if (tmr_en) begin
        if (value == 32'd0) value <= tmr_periodic ? load_val : 32'd0;
        else                value <= value - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq  <= 1'b0;
      firq <= 1'b0;
    end else begin
      irq  <= |irq_mask;
      firq <= |firq_mask;
    end
  end

  // Scan downward so the lowest-numbered active source ends up in irq_id.
  always_comb begin
    irq_id = 6'd32;
    for (int i = P - 1; i >= 0; i--) begin
      if (irq_mask[i]) irq_id = 6'(i);
    end
  end

  always_comb begin
    read_data = 32'd0;
    if (sel) begin
      case (reg_idx)
        REG_PENDING: read_data = 32'(pending);
        REG_ENABLE:  read_data = 32'(enable);
        REG_FIQSEL:  read_data = 32'(fiqsel);
        REG_CLEAR:   read_data = 32'd0;
        REG_LOAD:    read_data = load_val;
        REG_VALUE:   read_data = value;
        REG_TCTRL:   read_data = {30'd0, tmr_periodic, tmr_en};
        REG_ID:      read_data = 32'(irq_id);
        default:     read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a bit-level reference model compared every cycle,
// plus directed register accesses with hand-computed expectations.
module tb_irq_ctrl;

  localparam int NSRC = 4;
  localparam int P = NSRC + 1;
  localparam logic [31:0] PMASK = (32'd1 << P) - 32'd1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            sel = 1'b0;
  logic            we = 1'b0;
  logic [31:0]     addr = 32'd0;
  logic [31:0]     write_data = 32'd0;
  logic [31:0]     read_data;
  logic [NSRC-1:0] src = '0;
  logic            irq;
  logic            firq;

  int checks = 0;
  int failures = 0;
  bit compare_on = 1'b0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk(clk),
    .reset(reset),
    .sel(sel),
    .we(we),
    .addr(addr),
    .write_data(write_data),
    .read_data(read_data),
    .src(src),
    .irq(irq),
    .firq(firq)
  );

  always #5 clk = ~clk;

  bit [31:0]     m_pend, m_en, m_fiq, m_load, m_val, m_sets;
  bit            m_ten, m_tper, m_irq, m_firq, m_irq_n, m_firq_n;
  bit [NSRC-1:0] m_srcq;

  // Reference model: whole-word state advanced once per rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 0; m_en = 0; m_fiq = 0; m_load = 0; m_val = 0;
      m_ten = 0; m_tper = 0; m_irq = 0; m_firq = 0; m_srcq = '0;
    end else begin
      m_irq_n = 0;
      m_firq_n = 0;
      for (int i = 0; i < P; i++) begin
        if (m_pend[i] && m_en[i]) begin
          if (m_fiq[i]) m_firq_n = 1;
          else          m_irq_n = 1;
        end
      end
      m_sets = 0;
      for (int i = 0; i < NSRC; i++) if (src[i] && !m_srcq[i]) m_sets[i] = 1;
      if (m_ten) begin
        if (m_val == 0) begin
          m_sets[NSRC] = 1;
          if (m_tper) m_val = m_load;
          else        m_ten = 0;
        end else begin
          m_val = m_val - 1;
        end
      end
      if (sel && we) begin
        case (int'(addr[4:2]))
          1: m_en = write_data & PMASK;
          2: m_fiq = write_data & PMASK;
          3: m_pend = m_pend & ~write_data;
          4: begin m_load = write_data; m_val = write_data; end
          6: begin m_ten = write_data[0]; m_tper = write_data[1]; end
          default: ;
        endcase
      end
      m_pend = (m_pend | m_sets) & PMASK;
      m_srcq = src;
      m_irq  = m_irq_n;
      m_firq = m_firq_n;
    end
  end

  function automatic logic [31:0] model_read(input logic s, input logic [2:0] idx);
    logic [31:0] id;
    id = 32;
    for (int i = P - 1; i >= 0; i--) if (m_pend[i] && m_en[i] && !m_fiq[i]) id = i;
    if (!s) return 32'd0;
    case (idx)
      3'd0: return m_pend;
      3'd1: return m_en;
      3'd2: return m_fiq;
      3'd4: return m_load;
      3'd5: return m_val;
      3'd6: return {30'd0, m_tper, m_ten};
      3'd7: return id;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_on) begin
      checkOutput("model irq", {31'd0, irq}, {31'd0, m_irq});
      checkOutput("model firq", {31'd0, firq}, {31'd0, m_firq});
      checkOutput("model read_data", read_data, model_read(sel, addr[4:2]));
    end
  end

  task automatic applyStimulus(input logic [2:0] idx, input logic [31:0] data);
    sel = 1'b1;
    we = 1'b1;
    addr = {27'd0, idx, 2'b00};
    write_data = data;
    @(posedge clk);
    #1;
    sel = 1'b0;
    we = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] idx, input logic [31:0] expected, input string name);
    sel = 1'b1;
    we = 1'b0;
    addr = {27'd0, idx, 2'b00};
    #1;
    checkOutput(name, read_data, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_on = 1'b1;
    tick(1);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) readReg(3'(i), (i == 7) ? 32'h20 : 32'h0, "reset read");
    checkOutput("reset irq", {31'd0, irq}, 32'd0);
    checkOutput("reset firq", {31'd0, firq}, 32'd0);

    applyStimulus(3'd1, 32'h1F);
    src[2] = 1'b1;
    tick(1);
    readReg(3'd0, 32'h04, "edge pending");
    checkOutput("edge irq early", {31'd0, irq}, 32'd0);
    tick(1);
    checkOutput("edge irq", {31'd0, irq}, 32'd1);
    checkOutput("edge firq", {31'd0, firq}, 32'd0);
    readReg(3'd7, 32'd2, "edge id");
    applyStimulus(3'd3, 32'h04);
    readReg(3'd0, 32'h0, "clear pending");
    checkOutput("clear irq lag", {31'd0, irq}, 32'd1);
    tick(1);
    checkOutput("clear irq", {31'd0, irq}, 32'd0);
    src[2] = 1'b0;

    applyStimulus(3'd2, 32'h02);
    applyStimulus(3'd1, 32'h03);
    src[1:0] = 2'b11;
    tick(1);
    src[1:0] = 2'b00;
    tick(1);
    checkOutput("route irq", {31'd0, irq}, 32'd1);
    checkOutput("route firq", {31'd0, firq}, 32'd1);
    readReg(3'd7, 32'd0, "route id");
    applyStimulus(3'd3, 32'h01);
    tick(1);
    checkOutput("route irq cleared", {31'd0, irq}, 32'd0);
    checkOutput("route firq held", {31'd0, firq}, 32'd1);
    applyStimulus(3'd3, 32'h02);
    tick(1);

    applyStimulus(3'd2, 32'h0);
    applyStimulus(3'd1, 32'h10);
    applyStimulus(3'd4, 32'd3);
    readReg(3'd5, 32'd3, "load value");
    applyStimulus(3'd6, 32'h1);
    readReg(3'd5, 32'd3, "oneshot v3");
    readReg(3'd6, 32'h1, "oneshot tctrl");
    tick(1);
    readReg(3'd5, 32'd2, "oneshot v2");
    tick(1);
    readReg(3'd5, 32'd1, "oneshot v1");
    tick(1);
    readReg(3'd5, 32'd0, "oneshot v0");
    readReg(3'd0, 32'h0, "oneshot not yet");
    tick(1);
    readReg(3'd0, 32'h10, "oneshot fired");
    readReg(3'd6, 32'h0, "oneshot stopped");
    checkOutput("oneshot irq lag", {31'd0, irq}, 32'd0);
    tick(1);
    checkOutput("oneshot irq", {31'd0, irq}, 32'd1);
    readReg(3'd7, 32'd4, "oneshot id");

    applyStimulus(3'd3, 32'h10);
    applyStimulus(3'd4, 32'd1);
    applyStimulus(3'd6, 32'h3);
    readReg(3'd5, 32'd1, "periodic v1");
    readReg(3'd0, 32'h0, "periodic idle");
    tick(1);
    readReg(3'd5, 32'd0, "periodic v0");
    tick(1);
    readReg(3'd0, 32'h10, "periodic fire");
    readReg(3'd5, 32'd1, "periodic reload");
    applyStimulus(3'd3, 32'h10);
    readReg(3'd0, 32'h0, "periodic cleared");
    applyStimulus(3'd3, 32'h10);
    readReg(3'd0, 32'h10, "set wins");
    applyStimulus(3'd6, 32'h0);

    sel = 1'b0;
    we = 1'b0;
    addr = 32'h0;        #1 checkOutput("unsel 0x00", read_data, 32'h0);
    addr = 32'h1C;       #1 checkOutput("unsel 0x1C", read_data, 32'h0);
    addr = 32'hFFFFFFFF; #1 checkOutput("unsel ones", read_data, 32'h0);
    addr = 32'h4;
    write_data = 32'h0;
    we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
    readReg(3'd1, 32'h10, "unsel write ignored");
    applyStimulus(3'd1, 32'hFFFFFFFF);
    readReg(3'd1, 32'h1F, "enable mask");

    tick(1);
    checkOutput("pre reset irq", {31'd0, irq}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async irq", {31'd0, irq}, 32'd0);
    checkOutput("async firq", {31'd0, firq}, 32'd0);
    readReg(3'd0, 32'h0, "reset pending lost");
    readReg(3'd7, 32'h20, "reset id");
    tick(1);
    reset = 1'b1;
    tick(2);

    compare_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
